// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: issues the data-memory handshake for loads and stores, steers byte lanes and registers the result for writeback.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW are trapped with a bubble instead of being issued.
module rv32i_mem_stage #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP_IW  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_en_in,
  input  logic        w_en_in,
  input  logic [31:0] rs2_data_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic [31:0] alu_out,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en_out,
  output logic        bus_err,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [31:0]   dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]    dm_be_q, dm_be_d;
  logic [31:0]   alu_out_q, alu_out_d, iw_out_q, iw_out_d, pc_out_q, pc_out_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_reg_q, wb_reg_d;
  logic          wb_en_q, wb_en_d, bus_err_q, bus_err_d;
  logic          misalign_q, misalign_d;

  logic        is_load, is_store, is_mem, misaligned;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, req_wdata;
  logic [3:0]  req_be;
  logic        cap_inst, cap_bubble;

  assign is_load  = (iw_in[6:0] == 7'b0000011);
  assign is_store = (iw_in[6:0] == 7'b0100011);
  assign is_mem   = is_load | is_store;
  assign f3       = iw_in[14:12];
  assign off      = alu_in[1:0];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_mem && (((f3 == 3'b001 || f3 == 3'b101) && off[0]) ||
                                 (f3 == 3'b010 && off != 2'b00));
  assign misalign   = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    ld_byte = 8'h00;
    case (off)
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = dm_rdata;
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

  // Loads read the whole word; stores replicate the data across every lane the size could hit.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    if (is_store) begin
      req_wdata = rs2_data_in;
      case (f3)
        3'b000: begin
          req_be    = 4'b0001 << off;
          req_wdata = {4{rs2_data_in[7:0]}};
        end
        3'b001: begin
          req_be    = off[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{rs2_data_in[15:0]}};
        end
        3'b010:  req_be = 4'b1111;
        default: req_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    bus_err_d  = bus_err_q;
    alu_out_d  = alu_out_q;
    iw_out_d   = iw_out_q;
    pc_out_d   = pc_out_q;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;
    wb_en_d    = wb_en_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
    cap_inst   = 1'b0;
    cap_bubble = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!is_mem) begin
          cap_inst = 1'b1;
        end else if (misaligned) begin
          misalign_d = 1'b1;
          cap_bubble = 1'b1;
        end else begin
          stall      = 1'b1;
          cap_bubble = 1'b1;
          state_d    = S_ACCESS;
          cnt_d      = '0;
          dm_req_d   = 1'b1;
          dm_we_d    = is_store & w_en_in | is_store;
          dm_addr_d  = {alu_in[31:2], 2'b00};
          dm_be_d    = req_be;
          dm_wdata_d = req_wdata;
        end
      end
      default: begin
        // An ack arriving on the final count still completes the access.
        if (dm_ack || cnt_q == CW'(TIMEOUT - 1)) begin
          cap_inst   = dm_ack;
          cap_bubble = ~dm_ack;
          bus_err_d  = bus_err_q | ~dm_ack;
          state_d    = S_IDLE;
          cnt_d      = '0;
          dm_req_d   = 1'b0;
          dm_we_d    = 1'b0;
          dm_addr_d  = 32'h0;
          dm_be_d    = 4'b0000;
          dm_wdata_d = 32'h0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    if (cap_inst) begin
      alu_out_d = alu_in;
      iw_out_d  = iw_in;
      pc_out_d  = pc_in;
      wb_data_d = is_load ? ld_data : alu_in;
      wb_reg_d  = wb_reg_in;
      wb_en_d   = wb_en_in;
    end else if (cap_bubble) begin
      alu_out_d = 32'h0;
      iw_out_d  = NOP_IW;
      pc_out_d  = 32'h0;
      wb_data_d = 32'h0;
      wb_reg_d  = 5'd0;
      wb_en_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_be_q    <= 4'b0000;
      dm_wdata_q <= 32'h0;
      bus_err_q  <= 1'b0;
      alu_out_q  <= 32'h0;
      iw_out_q   <= NOP_IW;
      pc_out_q   <= 32'h0;
      wb_data_q  <= 32'h0;
      wb_reg_q   <= 5'd0;
      wb_en_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      bus_err_q  <= bus_err_d;
      alu_out_q  <= alu_out_d;
      iw_out_q   <= iw_out_d;
      pc_out_q   <= pc_out_d;
      wb_data_q  <= wb_data_d;
      wb_reg_q   <= wb_reg_d;
      wb_en_q    <= wb_en_d;
      misalign_q <= misalign_d;
    end
  end

  assign dm_req        = dm_req_q;
  assign dm_we         = dm_we_q;
  assign dm_addr       = dm_addr_q;
  assign dm_be         = dm_be_q;
  assign dm_wdata      = dm_wdata_q;
  assign bus_err       = bus_err_q;
  assign alu_out       = alu_out_q;
  assign iw_out        = iw_out_q;
  assign pc_out        = pc_out_q;
  assign wb_data_out   = wb_data_q;
  assign wb_reg_out    = wb_reg_q;
  assign wb_en_out     = wb_en_q;
  assign df_mem_enable = wb_en_q;
  assign df_mem_reg    = wb_reg_q;
  assign df_mem_data   = wb_data_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Directed plus randomized bench for rv32i_mem_stage against a lane-arithmetic reference model.
module tb_rv32i_mem_stage;
  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] alu_in = '0, iw_in = '0, pc_in = '0, rs2_data_in = '0, dm_rdata = '0;
  logic [4:0]  wb_reg_in = '0;
  logic        wb_en_in = 1'b0, w_en_in = 1'b0, dm_ack = 1'b0;
  logic        dm_req, dm_we, stall, wb_en_out, bus_err, df_mem_enable;
  logic [31:0] dm_addr, dm_wdata, alu_out, iw_out, pc_out, wb_data_out, df_mem_data;
  logic [3:0]  dm_be;
  logic [4:0]  wb_reg_out, df_mem_reg;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int vectors = 0, miscompares = 0;
  logic exp_bus_err = 1'b0;

  always #5 clk = ~clk;

  rv32i_mem_stage #(.TIMEOUT(TO), .NOP_IW(NOP)) dut (
    .clk(clk), .reset(reset), .alu_in(alu_in), .iw_in(iw_in), .pc_in(pc_in),
    .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .w_en_in(w_en_in), .rs2_data_in(rs2_data_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .alu_out(alu_out), .iw_out(iw_out),
    .pc_out(pc_out), .wb_data_out(wb_data_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
    .bus_err(bus_err), .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
    .df_mem_data(df_mem_data)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: lanes selected by shifting the read word, sign handled by subtraction.
  function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b - 256 : b;
      1: return (h >= 32768) ? h - 65536 : h;
      2: return rd;
      4: return b;
      5: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input bit ld, input int f3, input int off);
    if (ld) return 4'hF;
    case (f3)
      0: return 4'(1 << off);
      1: return (off >= 2) ? 4'hC : 4'h3;
      2: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] rs2);
    case (f3)
      0: return (rs2 & 32'hFF) * 32'h0101_0101;
      1: return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  task automatic set_in(input logic [31:0] iw, alu, pc, rs2, input logic [4:0] rg, input logic en);
    iw_in = iw; alu_in = alu; pc_in = pc; rs2_data_in = rs2;
    wb_reg_in = rg; wb_en_in = en; w_en_in = (iw[6:0] == 7'b0100011);
  endtask

  task automatic do_alu(input logic [31:0] iw, alu, pc, input logic [4:0] rg, input logic en,
                        input logic ack);
    set_in(iw, alu, pc, 32'h0, rg, en);
    dm_ack = ack;
    #1;
    chk("alu_stall", stall, 0);
    chk("alu_noreq", dm_req, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("alu_iw", iw_out, iw);
    chk("alu_wbdata", wb_data_out, alu);
    chk("alu_dfdata", df_mem_data, alu);
    chk("alu_wben", df_mem_enable, en);
    chk("alu_wbreg", df_mem_reg, rg);
    chk("alu_pc", pc_out, pc);
    chk("alu_buserr", bus_err, exp_bus_err);
  endtask

  task automatic do_mem(input logic [31:0] iw, alu, pc, rs2, input logic [4:0] rg, input logic en,
                        input int dly, input logic [31:0] rd);
    bit ld;
    int f3, off;
    logic [31:0] exp_data;
    ld  = (iw[6:0] == 7'b0000011);
    f3  = int'(iw[14:12]);
    off = int'(alu[1:0]);
    exp_data = ld ? ref_load(f3, off, rd) : alu;
    set_in(iw, alu, pc, rs2, rg, en);
    dm_ack = 1'b0;
    #1;
    chk("mem_idle_stall", stall, 1);
    @(posedge clk); #1;
    chk("mem_req", dm_req, 1);
    chk("mem_we", dm_we, !ld);
    chk("mem_addr", dm_addr, alu & 32'hFFFF_FFFC);
    chk("mem_be", dm_be, ref_be(ld, f3, off));
    if (!ld && f3 <= 2) chk("mem_wdata", dm_wdata, ref_wdata(f3, rs2));
    chk("mem_bubble_iw", iw_out, NOP);
    chk("mem_bubble_en", wb_en_out, 0);
    for (int k = 0; k < dly; k++) begin
      dm_rdata = $urandom;
      #1;
      chk("mem_wait_stall", stall, 1);
      @(posedge clk); #1;
      chk("mem_hold_req", dm_req, 1);
      chk("mem_hold_addr", dm_addr, alu & 32'hFFFF_FFFC);
    end
    dm_ack = 1'b1;
    dm_rdata = rd;
    #1;
    chk("mem_ack_stall", stall, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("mem_iw", iw_out, iw);
    chk("mem_wbdata", wb_data_out, exp_data);
    chk("mem_dfdata", df_mem_data, exp_data);
    chk("mem_wben", wb_en_out, en);
    chk("mem_wbreg", wb_reg_out, rg);
    chk("mem_alu", alu_out, alu);
    chk("mem_pc", pc_out, pc);
    chk("mem_req_drop", dm_req, 0);
    chk("mem_buserr", bus_err, exp_bus_err);
  endtask

  initial begin
    int cnt;
    logic [31:0] iw, alu, rs2;
    int kind, f3;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dm_req, 0);
    chk("rst_iw", iw_out, NOP);
    chk("rst_wben", wb_en_out, 0);
    chk("rst_buserr", bus_err, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_alu", alu_out, 0);
    reset = 1'b1;

    // ADD passes through in one cycle
    do_alu(32'h0020_80B3, 32'h0000_0005, 32'h0000_0040, 5'd1, 1'b1, 1'b0);

    // LB / LBU at 0x103, ack in the 2nd access cycle
    do_mem(32'h0000_0003, 32'h0000_0103, 32'h44, 32'h0, 5'd2, 1'b1, 1, 32'h80FF_1234);
    do_mem(32'h0000_4003, 32'h0000_0103, 32'h48, 32'h0, 5'd3, 1'b1, 1, 32'h80FF_1234);

    // SH at 0x202, immediate ack
    do_mem(32'h0000_1023, 32'h0000_0202, 32'h4C, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 32'h0);

    // Ack on the final timeout count wins
    do_mem(32'h0000_2003, 32'h0000_0300, 32'h50, 32'h0, 5'd4, 1'b1, TO - 1, 32'hCAFE_F00D);

    // Reset during an access drops the request at once
    set_in(32'h0000_2003, 32'h0000_0400, 32'h54, 32'h0, 5'd5, 1'b1);
    #1;
    @(posedge clk); #1;
    chk("rsta_req", dm_req, 1);
    reset = 1'b0;
    #1;
    chk("rsta_drop", dm_req, 0);
    dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    set_in(32'h0000_0033, 32'h0000_0077, 32'h58, 32'h0, 5'd6, 1'b1);
    reset = 1'b1;
    #1;
    chk("rsta_idle_stall", stall, 0);
    chk("rsta_iw", iw_out, NOP);
    chk("rsta_buserr", bus_err, 0);
    do_alu(32'h0000_0033, 32'h0000_0077, 32'h58, 5'd6, 1'b1, 1'b0);

    // Timeout: no ack
    set_in(32'h0000_2003, 32'h0000_0500, 32'h5C, 32'h0, 5'd7, 1'b1);
    dm_ack = 1'b0;
    #1;
    @(posedge clk); #1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!dm_req) break;
      cnt++;
      chk("to_stall", stall, (cnt < TO) ? 1 : 0);
      @(posedge clk); #1;
    end
    set_in(32'h0000_0033, 32'h0000_1234, 32'h60, 32'h0, 5'd8, 1'b1);
    exp_bus_err = 1'b1;
    chk("to_cycles", cnt, TO);
    chk("to_buserr", bus_err, 1);
    chk("to_wben", wb_en_out, 0);
    chk("to_iw", iw_out, NOP);
    do_alu(32'h0000_0033, 32'h0000_1234, 32'h60, 5'd8, 1'b1, 1'b0);

`ifdef MISALIGN_TRAP_EN
    set_in(32'h0000_2003, 32'h0000_0101, 32'h64, 32'h0, 5'd9, 1'b1);
    #1;
    chk("mis_stall", stall, 0);
    @(posedge clk); #1;
    set_in(32'h0000_0033, 32'h0000_0009, 32'h68, 32'h0, 5'd9, 1'b1);
    chk("mis_flag", misalign, 1);
    chk("mis_noreq", dm_req, 0);
    chk("mis_wben", wb_en_out, 0);
    chk("mis_iw", iw_out, NOP);
    do_alu(32'h0000_0033, 32'h0000_0009, 32'h68, 5'd9, 1'b1, 1'b0);
    chk("mis_clear", misalign, 0);
`endif

    // Random mix of ALU ops, loads and stores; acks in IDLE are noise
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(2);
      alu  = $urandom;
      rs2  = $urandom;
`ifdef MISALIGN_TRAP_EN
      alu[1:0] = 2'b00;
`endif
      if (kind == 0) begin
        iw = ($urandom & 32'hFFFF_FF80) | 32'h33;
        do_alu(iw, alu, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      end else if (kind == 1) begin
        f3 = $urandom_range(7);
        iw = ($urandom & 32'hFFFF_8F80) | (32'(f3) << 12) | 32'h03;
        do_mem(iw, alu, $urandom, rs2, 5'($urandom), 1'($urandom), $urandom_range(5), $urandom);
      end else begin
        f3 = $urandom_range(3);
        iw = ($urandom & 32'hFFFF_8F80) | (32'(f3) << 12) | 32'h23;
        do_mem(iw, alu, $urandom, rs2, 5'($urandom), 1'b0, $urandom_range(5), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
